// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the subsystems it releases.
// The sequencer drives the per-stage resets and status, and the subsystems return
// per-stage ready plus the software re-run request.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  localparam int FSW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;

  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_reset;
  logic                  all_ready;
  logic                  fault;
  logic [FSW-1:0]        fault_stage;

  modport master (
    input  sw_reset_req,
    input  stage_ready,
    output stage_reset,
    output all_ready,
    output fault,
    output fault_stage
  );

  modport slave (
    output sw_reset_req,
    output stage_ready,
    input  stage_reset,
    input  all_ready,
    input  fault,
    input  fault_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases subsystem resets one at a time in index order. Each released stage must
// report ready within a timeout, and must have settled for a minimum delay, before the
// next one is released. A missing or dropped ready puts every stage back into reset.
// One 8-bit timer is shared by the hold, settle and timeout phases.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk_25,
  input  logic               sys_reset,
  reset_sequencer_if.master  bus
);

  localparam int IW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;

  localparam logic [7:0]    HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    DELAY_LAST = 8'(STAGE_DELAY - 1);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t                state_q;
  logic [7:0]            timer_q;
  logic [IW-1:0]         idx_q;
  logic [NUM_STAGES-1:0] stage_reset_q;
  logic                  all_ready_q;
  logic                  fault_q;
  logic [IW-1:0]         fault_stage_q;

  logic [NUM_STAGES-1:0] verified_s;
  logic [NUM_STAGES-1:0] drop_mask_s;
  logic                  drop_any_s;
  logic [IW-1:0]         drop_idx_s;
  logic                  ready_cur_s;

  // Stages already acknowledged (below idx in WAIT, all in RUN) and the lowest one that lost ready.
  always_comb begin
    verified_s = '0;
    drop_idx_s = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      verified_s[j] = (state_q == ST_RUN) || ((state_q == ST_WAIT) && (j < int'(idx_q)));
    end
    drop_mask_s = verified_s & ~bus.stage_ready;
    drop_any_s  = |drop_mask_s;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (drop_mask_s[j]) begin
        drop_idx_s = IW'(j);
      end else begin
        drop_idx_s = drop_idx_s;
      end
    end
    ready_cur_s = bus.stage_ready[idx_q];
  end

  // Sequencer FSM with registered per-stage resets and status outputs.
  always_ff @(posedge clk_25) begin
    if (sys_reset) begin
      state_q       <= ST_HOLD;
      timer_q       <= 8'd0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else if (bus.sw_reset_req) begin
      state_q       <= ST_HOLD;
      timer_q       <= 8'd0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else if (drop_any_s) begin
      state_q       <= ST_FAULT;
      timer_q       <= 8'd0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b1;
      fault_stage_q <= drop_idx_s;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_q <= ST_RELEASE;
            timer_q <= 8'd0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ST_RELEASE: begin
          stage_reset_q[idx_q] <= 1'b0;
          timer_q              <= 8'd0;
          state_q              <= ST_WAIT;
        end
        ST_WAIT: begin
          // A ready arriving on the timeout cycle still counts as success.
          if ((timer_q >= DELAY_LAST) && ready_cur_s) begin
            timer_q <= 8'd0;
            if (idx_q == LAST_IDX) begin
              state_q     <= ST_RUN;
              all_ready_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= ST_RELEASE;
            end
          end else if (timer_q == TO_LAST) begin
            state_q       <= ST_FAULT;
            timer_q       <= 8'd0;
            stage_reset_q <= '1;
            fault_q       <= 1'b1;
            fault_stage_q <= idx_q;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        ST_FAULT: begin
          state_q       <= ST_FAULT;
          stage_reset_q <= '1;
        end
        default: begin
          state_q       <= ST_HOLD;
          timer_q       <= 8'd0;
          idx_q         <= '0;
          stage_reset_q <= '1;
          all_ready_q   <= 1'b0;
          fault_q       <= 1'b0;
          fault_stage_q <= '0;
        end
      endcase
    end
  end

  assign bus.stage_reset = stage_reset_q;
  assign bus.all_ready   = all_ready_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters. Cycle numbers follow
// the design timing: cycle 0 is the first HOLD cycle with sys_reset low.
module tb_reset_sequencer;

  localparam int NS = 4;

  logic clk_25 = 1'b0;
  logic sys_reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES (NS),
    .HOLD_CYCLES(8),
    .STAGE_DELAY(16),
    .TIMEOUT    (64)
  ) dut (
    .clk_25   (clk_25),
    .sys_reset(sys_reset),
    .bus      (bus)
  );

  // 25 MHz clock.
  always #20 clk_25 = ~clk_25;

  task automatic step();
    @(posedge clk_25);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stage_reset"}, 8'(bus.stage_reset), 8'h0F);
    chk({tag, "_all_ready"},   8'(bus.all_ready),   8'h00);
    chk({tag, "_fault"},       8'(bus.fault),       8'h00);
    chk({tag, "_fault_stage"}, 8'(bus.fault_stage), 8'h00);
  endtask

  // Pulse sw_reset_req for one cycle; on return cyc = 0 (first HOLD cycle).
  task automatic sw_restart(input logic [NS-1:0] rdy);
    bus.sw_reset_req = 1'b1;
    bus.stage_ready  = rdy;
    step();
    bus.sw_reset_req = 1'b0;
    cyc = 0;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    cyc              = 0;
    sys_reset        = 1'b1;
    bus.sw_reset_req = 1'b0;
    bus.stage_ready  = 4'hF;

    // Reset values, then sys_reset together with sw_reset_req.
    step(); step(); step();
    chk_reset_vals("reset");
    bus.sw_reset_req = 1'b1;
    step(); step();
    chk_reset_vals("rst_and_sw");
    bus.sw_reset_req = 1'b0;
    step();
    sys_reset = 1'b0;
    cyc = 0;

    // Nominal sequence.
    run_to(8);  chk("nom_c8",  8'(bus.stage_reset), 8'h0F);
    run_to(9);  chk("nom_c9",  8'(bus.stage_reset), 8'h0E);
    run_to(25); chk("nom_c25", 8'(bus.stage_reset), 8'h0E);
    run_to(26); chk("nom_c26", 8'(bus.stage_reset), 8'h0C);
    run_to(43); chk("nom_c43", 8'(bus.stage_reset), 8'h08);
    run_to(59); chk("nom_c59", 8'(bus.stage_reset), 8'h08);
    run_to(60); chk("nom_c60", 8'(bus.stage_reset), 8'h00);
    run_to(75); chk("nom_c75_ar", 8'(bus.all_ready), 8'h00);
    run_to(76); chk("nom_c76_ar", 8'(bus.all_ready), 8'h01);
    chk("nom_c76_fault", 8'(bus.fault), 8'h00);

    // RUN-time drop of stages 3 and 1 together.
    run_to(80);
    chk("drop_pre_ar", 8'(bus.all_ready), 8'h01);
    bus.stage_ready = 4'b0101;
    step();
    chk("drop_fault",       8'(bus.fault),       8'h01);
    chk("drop_fault_stage", 8'(bus.fault_stage), 8'h01);
    chk("drop_all_ready",   8'(bus.all_ready),   8'h00);
    chk("drop_stage_reset", 8'(bus.stage_reset), 8'h0F);
    bus.stage_ready = 4'hF;
    step(); step(); step();
    chk("fault_sticky",       8'(bus.fault),       8'h01);
    chk("fault_stage_sticky", 8'(bus.fault_stage), 8'h01);

    // Stage 2 never ready: timeout.
    sw_restart(4'b1011);
    chk_reset_vals("sw_after_fault");
    run_to(43);  chk("to_c43",       8'(bus.stage_reset), 8'h08);
    run_to(106); chk("to_c106_fault", 8'(bus.fault), 8'h00);
    run_to(107);
    chk("to_c107_fault",       8'(bus.fault),       8'h01);
    chk("to_c107_fault_stage", 8'(bus.fault_stage), 8'h02);
    chk("to_c107_stage_reset", 8'(bus.stage_reset), 8'h0F);

    // Stage 1 ready arrives late, at cycle 50.
    sw_restart(4'b1101);
    chk("late_c0_fault", 8'(bus.fault), 8'h00);
    run_to(26); chk("late_c26", 8'(bus.stage_reset), 8'h0C);
    run_to(50);
    bus.stage_ready = 4'hF;
    run_to(51); chk("late_c51", 8'(bus.stage_reset), 8'h0C);
    run_to(52); chk("late_c52", 8'(bus.stage_reset), 8'h08);
    chk("late_c52_fault", 8'(bus.fault), 8'h00);
    run_to(69); chk("late_c69", 8'(bus.stage_reset), 8'h00);
    run_to(84); chk("late_c84_ar", 8'(bus.all_ready), 8'h00);
    run_to(85); chk("late_c85_ar", 8'(bus.all_ready), 8'h01);

    // sys_reset mid-WAIT, then nominal timing from the new cycle 0.
    sw_restart(4'hF);
    run_to(30);
    chk("mid_c30", 8'(bus.stage_reset), 8'h0C);
    sys_reset = 1'b1;
    step();
    chk_reset_vals("mid_rst");
    bus.sw_reset_req = 1'b1;
    step(); step();
    chk_reset_vals("mid_rst_sw");
    bus.sw_reset_req = 1'b0;
    sys_reset = 1'b0;
    cyc = 0;
    run_to(8);  chk("mid_c8",  8'(bus.stage_reset), 8'h0F);
    run_to(9);  chk("mid_c9",  8'(bus.stage_reset), 8'h0E);
    run_to(26); chk("mid_c26", 8'(bus.stage_reset), 8'h0C);
    run_to(76); chk("mid_c76_ar", 8'(bus.all_ready), 8'h01);

    // Ready rising exactly on the last timeout count wins over the timeout.
    sw_restart(4'b1011);
    run_to(106);
    chk("coin_c106", 8'(bus.stage_reset), 8'h08);
    bus.stage_ready = 4'hF;
    run_to(107);
    chk("coin_c107_fault", 8'(bus.fault), 8'h00);
    chk("coin_c107_sr",    8'(bus.stage_reset), 8'h08);
    run_to(108);
    chk("coin_c108_sr",    8'(bus.stage_reset), 8'h00);
    run_to(123); chk("coin_c123_ar", 8'(bus.all_ready), 8'h00);
    run_to(124); chk("coin_c124_ar", 8'(bus.all_ready), 8'h01);
    chk("coin_c124_fault", 8'(bus.fault), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
